// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } fetchState_e;

  localparam logic [31:0] INST_BUBBLE = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'd4;

  // Redirect targets are word-aligned by dropping the byte offset.
  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: redirect/stall controls, memory load port and fetched instruction.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_W = 8
);

    logic              Stall;
    logic              BranchTaken;
    logic [31:0]       BranchTarget;
    logic              ImemWE;
    logic [ADDR_W-1:0] ImemWA;
    logic [31:0]       ImemWD;
    logic [31:0]       Inst;
    logic              InstValid;
    logic [31:0]       PC;
    logic [31:0]       PCPlus4;

    modport master (
        output Stall, BranchTaken, BranchTarget, ImemWE, ImemWA, ImemWD,
        input  Inst, InstValid, PC, PCPlus4
    );

    modport slave (
        input  Stall, BranchTaken, BranchTarget, ImemWE, ImemWA, ImemWD,
        output Inst, InstValid, PC, PCPlus4
    );

endinterface

// File: rtl/inst_memory.sv
// Instruction memory: one synchronous read port, one write port, read-before-write.
module inst_memory #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              CLK,
    input  logic              RdEn,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic [31:0]       RdData,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [31:0]       WrData
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [31:0] mem [Depth];

    // Both updates are non-blocking, so a colliding read sees the pre-write word.
    always_ff @(posedge CLK) begin
        if (WrEn) begin
            mem[WrAddr] <= WrData;
        end
        if (RdEn) begin
            RdData <= mem[RdAddr];
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, boot/redirect FSM and instruction memory front end.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic CLK,
    input logic RSTn,
    instruction_fetch_if.slave bus
);

    fetchState_e       stateQ, stateD;
    logic [31:0]       fpcQ, fpcD;
    logic [31:0]       pcQ, pcD;
    logic              rdEn;
    logic [ADDR_W-1:0] rdAddr;
    logic [31:0]       rdData;

    assign rdAddr = fpcQ[ADDR_W+1:2];

    inst_memory #(
        .ADDR_W(ADDR_W)
    ) uMem (
        .CLK   (CLK),
        .RdEn  (rdEn),
        .RdAddr(rdAddr),
        .RdData(rdData),
        .WrEn  (bus.ImemWE),
        .WrAddr(bus.ImemWA),
        .WrData(bus.ImemWD)
    );

    // BOOT and REDIR behave identically; they differ only in how the bubble arose.
    always_comb begin
        stateD = stateQ;
        fpcD   = fpcQ;
        pcD    = pcQ;
        rdEn   = 1'b0;
        if (bus.BranchTaken) begin
            fpcD   = alignPc(bus.BranchTarget);
            stateD = REDIR;
        end else if (!bus.Stall) begin
            rdEn   = 1'b1;
            pcD    = fpcQ;
            fpcD   = fpcQ + PC_STEP;
            stateD = RUN;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            stateQ <= BOOT;
            fpcQ   <= RESET_PC;
            pcQ    <= RESET_PC;
        end else begin
            stateQ <= stateD;
            fpcQ   <= fpcD;
            pcQ    <= pcD;
        end
    end

    // The memory read register is not reset; the bubble mux hides it outside RUN.
    assign bus.InstValid = (stateQ == RUN);
    assign bus.Inst      = bus.InstValid ? rdData : INST_BUBBLE;
    assign bus.PC        = pcQ;
    assign bus.PCPlus4   = pcQ + PC_STEP;

endmodule
